// File: rtl/tictactoe_pkg.sv
// tictactoe_pkg: controller state encoding and the eight winning cell masks.
// Board bit i is cell i, row-major, with cell 0 at the top-left.
package tictactoe_pkg;

    typedef enum logic [2:0] {START, PLAY, CHECK, WIN_X, WIN_O, TIE} state_t;

    localparam logic [7:0][8:0] WIN_LINES = {
        9'b001_010_100, 9'b100_010_001,
        9'b100_100_100, 9'b010_010_010, 9'b001_001_001,
        9'b111_000_000, 9'b000_111_000, 9'b000_000_111
    };

    localparam logic [8:0] FULL_BOARD = 9'h1ff;

endpackage

// File: rtl/line_check.sv
// line_check: flags a board that covers at least one complete win line.
module line_check
    import tictactoe_pkg::*;
(
    input  logic [8:0] board,
    output logic       win
);

    always_comb begin
        win = 1'b0;
        for (int i = 0; i < 8; i++)
            win = win | ((board & WIN_LINES[i]) == WIN_LINES[i]);
    end

endmodule

// File: rtl/turn_controller.sv
// turn_controller: tic-tac-toe game sequencer; owns boards, turn, screen state and scores.
// A move lands one edge after the press and its outcome is resolved on the following edge.
module turn_controller
    import tictactoe_pkg::*;
#(
    parameter int SCORE_W = 4
) (
    input  logic               clk_100MHz,
    input  logic               reset,
    input  logic [8:0]         square,
    input  logic               start,
    input  logic               restart,
    input  logic               reset_score,
    output logic [8:0]         x_board,
    output logic [8:0]         o_board,
    output logic               turn_x,
    output logic               scr_start,
    output logic               scr_play,
    output logic               scr_win_x,
    output logic               scr_win_o,
    output logic               scr_tie,
    output logic [SCORE_W-1:0] x_score,
    output logic [SCORE_W-1:0] o_score
);

    state_t     state;
    logic [8:0] sq_q;
    logic [8:0] mover_board;
    logic       new_press;
    logic       can_move;
    logic       mover_win;
    logic       board_full;

    // A press is the rising of a single button; holds and chords never count.
    assign new_press   = (sq_q == '0) && (square != '0) && ((square & (square - 9'd1)) == '0);
    assign can_move    = new_press && (((x_board | o_board) & square) == '0);
    // turn_x has already flipped by CHECK, so the mover is the other player.
    assign mover_board = turn_x ? o_board : x_board;
    assign board_full  = (x_board | o_board) == FULL_BOARD;

    line_check u_line_check (
        .board (mover_board),
        .win   (mover_win)
    );

    assign scr_start = state == START;
    assign scr_play  = (state == PLAY) || (state == CHECK);
    assign scr_win_x = state == WIN_X;
    assign scr_win_o = state == WIN_O;
    assign scr_tie   = state == TIE;

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            state   <= START;
            x_board <= '0;
            o_board <= '0;
            turn_x  <= 1'b1;
            x_score <= '0;
            o_score <= '0;
            sq_q    <= '0;
        end else begin
            sq_q <= square;
            if (restart) begin
                state   <= START;
                x_board <= '0;
                o_board <= '0;
                turn_x  <= 1'b1;
            end else begin
                case (state)
                    START, WIN_X, WIN_O, TIE: begin
                        if (start) begin
                            state   <= PLAY;
                            x_board <= '0;
                            o_board <= '0;
                            turn_x  <= 1'b1;
                        end
                    end
                    PLAY: begin
                        if (can_move) begin
                            if (turn_x) x_board <= x_board | square;
                            else        o_board <= o_board | square;
                            turn_x <= !turn_x;
                            state  <= CHECK;
                        end
                    end
                    CHECK:   state <= mover_win ? (turn_x ? WIN_O : WIN_X) : board_full ? TIE : PLAY;
                    default: state <= START;
                endcase
            end
            // A score clear beats the win being credited on the same edge.
            if (reset_score) begin
                x_score <= '0;
                o_score <= '0;
            end else if (!restart && state == CHECK && mover_win) begin
                if (turn_x) begin
                    if (o_score != '1) o_score <= o_score + 1'b1;
                end else begin
                    if (x_score != '1) x_score <= x_score + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_turn_controller.sv
// tb_turn_controller: scenario and randomized checks of turn_controller against a cell-ownership model.
module tb_turn_controller;

    localparam int SW = 2;
    localparam int MAXS = 3;
    localparam int S_START = 0, S_PLAY = 1, S_WX = 2, S_WO = 3, S_TIE = 4;

    logic          clk = 1'b0;
    logic          reset, start, restart, reset_score;
    logic [8:0]    square;
    logic [8:0]    x_board, o_board;
    logic          turn_x, scr_start, scr_play, scr_win_x, scr_win_o, scr_tie;
    logic [SW-1:0] x_score, o_score;
    logic [27:0]   obs;

    int checks = 0;
    int errors = 0;

    // Model: owner per cell (0 empty, 1 X, 2 O), screen, next mover, scores.
    int own[9];
    bit m_turn;
    int m_scr, m_xs, m_os;
    int lines[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6}, '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

    turn_controller #(.SCORE_W(SW)) dut (
        .clk_100MHz  (clk),
        .reset       (reset),
        .square      (square),
        .start       (start),
        .restart     (restart),
        .reset_score (reset_score),
        .x_board     (x_board),
        .o_board     (o_board),
        .turn_x      (turn_x),
        .scr_start   (scr_start),
        .scr_play    (scr_play),
        .scr_win_x   (scr_win_x),
        .scr_win_o   (scr_win_o),
        .scr_tie     (scr_tie),
        .x_score     (x_score),
        .o_score     (o_score)
    );

    always #5 clk = ~clk;

    assign obs = {x_board, o_board, turn_x, scr_start, scr_play, scr_win_x, scr_win_o, scr_tie, x_score, o_score};

    function automatic logic [27:0] expv();
        logic [8:0] bx, bo;
        logic [4:0] scr;
        bx = '0;
        bo = '0;
        for (int i = 0; i < 9; i++) begin
            bx[i] = own[i] == 1;
            bo[i] = own[i] == 2;
        end
        scr = 5'b10000 >> m_scr;
        return {bx, bo, m_turn, scr, m_xs[SW-1:0], m_os[SW-1:0]};
    endfunction

    function automatic bit m_won(int p);
        for (int i = 0; i < 8; i++)
            if (own[lines[i][0]] == p && own[lines[i][1]] == p && own[lines[i][2]] == p) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void m_clear();
        for (int i = 0; i < 9; i++) own[i] = 0;
        m_turn = 1'b1;
    endfunction

    function automatic void m_reset();
        m_clear();
        m_scr = S_START;
        m_xs = 0;
        m_os = 0;
    endfunction

    function automatic void m_start();
        if (m_scr != S_PLAY) begin
            m_clear();
            m_scr = S_PLAY;
        end
    endfunction

    function automatic void m_restart();
        m_clear();
        m_scr = S_START;
    endfunction

    function automatic void m_press(int c);
        int p;
        bit full;
        if (m_scr != S_PLAY || own[c] != 0) return;
        p = m_turn ? 1 : 2;
        own[c] = p;
        m_turn = !m_turn;
        full = 1'b1;
        for (int i = 0; i < 9; i++) if (own[i] == 0) full = 1'b0;
        if (m_won(p)) begin
            m_scr = (p == 1) ? S_WX : S_WO;
            if (p == 1 && m_xs < MAXS) m_xs++;
            if (p == 2 && m_os < MAXS) m_os++;
        end else if (full) m_scr = S_TIE;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_click(int c);
        square = 9'd1 << c;
        tick();
        square = '0;
        tick();
        m_press(c);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        m_start();
    endtask

    task automatic do_restart();
        restart = 1'b1;
        tick();
        restart = 1'b0;
        tick();
        m_restart();
    endtask

    task automatic do_rstscore();
        reset_score = 1'b1;
        tick();
        reset_score = 1'b0;
        tick();
        m_xs = 0;
        m_os = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2;
        m_reset();
        checks++;
        if (obs !== expv()) begin
            errors++;
            $display("FAIL reset_state: got %h want %h", obs, expv());
        end
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if (scr_start !== 1'b1 || obs !== expv()) begin
            errors++;
            $display("FAIL reset_release: got %h want %h", obs, expv());
        end
    endtask

    task automatic test_win_x();
        do_start();
        checks++;
        if (scr_play !== 1'b1 || turn_x !== 1'b1) begin
            errors++;
            $display("FAIL start_to_play: got play=%b turn=%b want 1 1", scr_play, turn_x);
        end
        do_click(0);
        do_click(3);
        do_click(1);
        do_click(4);
        square = 9'b000000100;
        tick();
        checks++;
        if (x_board !== 9'b000000111 || scr_play !== 1'b1 || scr_win_x !== 1'b0) begin
            errors++;
            $display("FAIL win_x_n1: got xb=%b play=%b winx=%b want 000000111 1 0", x_board, scr_play, scr_win_x);
        end
        square = '0;
        tick();
        m_press(2);
        checks++;
        if (scr_win_x !== 1'b1 || x_score !== 2'd1 || x_board !== 9'b000000111 || obs !== expv()) begin
            errors++;
            $display("FAIL win_x_n2: got %h want %h", obs, expv());
        end
    endtask

    task automatic test_held();
        do_start();
        square = 9'b000010000;
        repeat (50) tick();
        square = '0;
        tick();
        m_press(4);
        checks++;
        if (x_board !== 9'b000010000 || o_board !== 9'b0 || turn_x !== 1'b0 || obs !== expv()) begin
            errors++;
            $display("FAIL held_button: got %h want %h", obs, expv());
        end
    endtask

    task automatic test_occupied();
        do_click(4);
        checks++;
        if (scr_play !== 1'b1 || turn_x !== 1'b0 || o_board !== 9'b0 || obs !== expv()) begin
            errors++;
            $display("FAIL occupied_cell: got %h want %h", obs, expv());
        end
    endtask

    task automatic test_tie_and_late_win();
        int tie_seq[9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
        int win_seq[9] = '{0, 1, 2, 4, 5, 3, 7, 6, 8};
        do_restart();
        do_start();
        foreach (tie_seq[i]) do_click(tie_seq[i]);
        checks++;
        if (scr_tie !== 1'b1 || obs !== expv()) begin
            errors++;
            $display("FAIL full_board_tie: got %h want %h", obs, expv());
        end
        do_start();
        foreach (win_seq[i]) do_click(win_seq[i]);
        checks++;
        if (scr_win_x !== 1'b1 || scr_tie !== 1'b0 || x_score !== 2'd2 || obs !== expv()) begin
            errors++;
            $display("FAIL ninth_move_win: got %h want %h", obs, expv());
        end
    endtask

    task automatic test_restart_press();
        do_start();
        do_click(0);
        restart = 1'b1;
        square = 9'b000100000;
        tick();
        restart = 1'b0;
        square = '0;
        tick();
        m_restart();
        checks++;
        if (scr_start !== 1'b1 || x_board !== 9'b0 || x_score !== 2'd2 || obs !== expv()) begin
            errors++;
            $display("FAIL restart_over_press: got %h want %h", obs, expv());
        end
        do_click(3);
        checks++;
        if (obs !== expv()) begin
            errors++;
            $display("FAIL press_in_start: got %h want %h", obs, expv());
        end
        do_rstscore();
        checks++;
        if (x_score !== 2'd0 || o_score !== 2'd0 || obs !== expv()) begin
            errors++;
            $display("FAIL reset_score: got %h want %h", obs, expv());
        end
    endtask

    task automatic test_rstscore_priority();
        do_start();
        do_click(0);
        do_click(3);
        do_click(1);
        do_click(4);
        square = 9'b000000100;
        tick();
        square = '0;
        reset_score = 1'b1;
        tick();
        reset_score = 1'b0;
        m_press(2);
        m_xs = 0;
        m_os = 0;
        checks++;
        if (scr_win_x !== 1'b1 || x_score !== 2'd0 || obs !== expv()) begin
            errors++;
            $display("FAIL clear_beats_increment: got %h want %h", obs, expv());
        end
    endtask

    task automatic test_reset_midgame();
        do_start();
        do_click(0);
        do_click(3);
        do_click(1);
        do_click(4);
        square = 9'b000000100;
        tick();
        square = '0;
        #2;
        reset = 1'b1;
        #1;
        m_reset();
        checks++;
        if (scr_start !== 1'b1 || obs !== expv()) begin
            errors++;
            $display("FAIL async_reset_midgame: got %h want %h", obs, expv());
        end
        tick();
        reset = 1'b0;
        repeat (3) tick();
        checks++;
        if (obs !== expv()) begin
            errors++;
            $display("FAIL pending_check_dropped: got %h want %h", obs, expv());
        end
    endtask

    task automatic test_saturate();
        repeat (5) begin
            do_start();
            do_click(0);
            do_click(3);
            do_click(1);
            do_click(4);
            do_click(2);
        end
        checks++;
        if (x_score !== 2'd3 || obs !== expv()) begin
            errors++;
            $display("FAIL score_saturate: got %h want %h", obs, expv());
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            int r, a, b;
            r = $urandom_range(0, 39);
            if (r == 0) do_restart();
            else if (r == 1) do_rstscore();
            else if (r < 5) do_start();
            else if (r < 7) begin
                a = $urandom_range(0, 8);
                b = (a + $urandom_range(1, 8)) % 9;
                square = (9'd1 << a) | (9'd1 << b);
                repeat (2) tick();
                square = '0;
                tick();
            end else do_click($urandom_range(0, 8));
            checks++;
            if (obs !== expv()) begin
                errors++;
                $display("FAIL random_step%0d: got %h want %h", n, obs, expv());
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        restart = 1'b0;
        reset_score = 1'b0;
        square = '0;
        test_reset();
        test_win_x();
        test_held();
        test_occupied();
        test_tie_and_late_win();
        test_restart_press();
        test_rstscore_priority();
        test_reset_midgame();
        test_saturate();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
